// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: FSM encoding, protocol byte constants and
// rx_key / key_out field positions.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACKBIT,
    ST_WAITRESP
  } ps2_state_e;

  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_SET_LED = 8'hED;

  localparam int KEY_W        = 11;
  localparam int KEY_STB      = 10;
  localparam int KEY_PRESSED  = 9;
  localparam int KEY_EXT      = 8;
  localparam int KEY_CODE_MSB = 7;
  localparam int KEY_CODE_LSB = 0;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Host-to-device command handshake between a command source (master) and
// the PS/2 host controller (slave).
interface ps2_host_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_ready;
  logic       cmd_ack;
  logic       cmd_err;

  modport master (output cmd_valid, cmd_byte, input  cmd_ready, cmd_ack, cmd_err);
  modport slave  (input  cmd_valid, cmd_byte, output cmd_ready, cmd_ack, cmd_err);
endinterface

// File: rtl/ps2_tx_shift.sv
// Host-to-device frame shifter: start, 8 data bits LSB first, odd parity, stop.
// bit_out is the level currently presented; each shift presents the next bit.
module ps2_tx_shift
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       shift,
  output logic       bit_out,
  output logic       at_parity
);

  logic [10:0] sr;
  logic [3:0]  cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '1;
      cnt <= '0;
    end else if (load) begin
      sr  <= {1'b1, odd_parity(data), data, 1'b0};
      cnt <= '0;
    end else if (shift) begin
      sr  <= {1'b1, sr[10:1]};
      if (cnt != 4'd10) cnt <= cnt + 4'd1;
    end
  end

  assign bit_out   = sr[0];
  // Parity is on the line; the next shift presents the stop bit.
  assign at_parity = (cnt == 4'd9);

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller: sends command bytes to a device with resend/retry and
// timeout handling, and filters ACK/RESEND out of the key event stream.
// Optional LED auto-sync (0xED + LED byte) when PS2_LED_SYNC_EN is defined.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 3200,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY      = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             ps2_clk_oe,
  output logic             ps2_data_oe,
  input  logic [KEY_W-1:0] rx_key,
  output logic [KEY_W-1:0] key_out,
  output logic             busy,
`ifdef PS2_LED_SYNC_EN
  input  logic [2:0]       led_state,
`endif
  ps2_host_ctrl_if.slave   cmd
);

  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [1:0] LED_NONE = 2'd0, LED_CMD = 2'd1, LED_VAL = 2'd2;

  ps2_state_e    state_q, state_d;
  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fall, dat_s;
  logic [CW-1:0] cnt;
  logic          timeout;
  logic [7:0]    tx_byte, retry;
  logic          tx_bit, tx_at_parity;
  logic          ack_q, ack_d, err_q, err_d;
  logic          accept, led_start, led_next, retry_inc;
  logic          rx_stb, resp_hit;
  logic [7:0]    rx_code;
  logic          led_pend;
  logic [1:0]    led_phase;
  logic [2:0]    led_snap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  assign fall  = clk_sync[2] & ~clk_sync[1];
  assign dat_s = dat_sync[1];

  assign rx_stb   = rx_key[KEY_STB];
  assign rx_code  = rx_key[KEY_CODE_MSB:KEY_CODE_LSB];
  assign resp_hit = rx_stb && (state_q == ST_WAITRESP) &&
                    ((rx_code == PS2_ACK) || (rx_code == PS2_RESEND));
  assign timeout  = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    accept    = 1'b0;
    led_start = 1'b0;
    led_next  = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_INHIBIT;
        end else if (led_pend) begin
          led_start = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: if (cnt == CW'(INHIBIT_CYCLES)) state_d = ST_REQ;
      ST_REQ:     state_d = ST_SEND;
      ST_SEND: begin
        if (fall) begin
          if (tx_at_parity) state_d = ST_ACKBIT;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ACKBIT: begin
        if (fall) begin
          if (!dat_s) state_d = ST_WAITRESP;
          else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAITRESP: begin
        if (rx_stb && rx_code == PS2_ACK) begin
          // 0xED is acknowledged silently; the LED byte carries the one ack.
          if (led_phase == LED_CMD) begin
            led_next = 1'b1;
            state_d  = ST_INHIBIT;
          end else begin
            ack_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (rx_stb && rx_code == PS2_RESEND) begin
          if (retry < 8'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_d   = ST_INHIBIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      key_out <= '0;
      tx_byte <= '0;
      retry   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      key_out <= resp_hit ? {1'b0, rx_key[KEY_STB-1:0]} : rx_key;
      if (accept)         tx_byte <= cmd.cmd_byte;
      else if (led_start) tx_byte <= PS2_SET_LED;
      else if (led_next)  tx_byte <= {5'b0, led_snap};
      if (accept || led_start || led_next) retry <= '0;
      else if (retry_inc)                  retry <= retry + 8'd1;
    end
  end

  // Shared inhibit/timeout counter. While inhibiting, the falling edge is our
  // own pull-down seen back through the synchroniser, so it must not reload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if ((state_d != state_q) || (fall && state_q != ST_INHIBIT))
      cnt <= CW'(1);
    else if (state_q != ST_IDLE)
      cnt <= cnt + CW'(1);
  end

`ifdef PS2_LED_SYNC_EN
  logic [2:0] led_sent;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_sent  <= '0;
      led_snap  <= '0;
      led_phase <= LED_NONE;
    end else if (led_start) begin
      led_snap  <= led_state;
      led_phase <= LED_CMD;
    end else if (led_next) begin
      led_phase <= LED_VAL;
    end else if (ack_d && led_phase == LED_VAL) begin
      led_sent  <= led_snap;
      led_phase <= LED_NONE;
    end else if (err_d) begin
      led_phase <= LED_NONE;
    end
  end

  assign led_pend = (led_state != led_sent);
`else
  assign led_pend  = 1'b0;
  assign led_phase = LED_NONE;
  assign led_snap  = 3'b000;
`endif

  ps2_tx_shift u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (state_q == ST_REQ),
    .data      (tx_byte),
    .shift     ((state_q == ST_SEND) && fall),
    .bit_out   (tx_bit),
    .at_parity (tx_at_parity)
  );

  assign ps2_clk_oe    = (state_q == ST_INHIBIT);
  assign ps2_data_oe   = (state_q == ST_REQ) || ((state_q == ST_SEND) && !tx_bit);
  assign busy          = (state_q != ST_IDLE);
  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.cmd_ack   = ack_q;
  assign cmd.cmd_err   = err_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Self-checking bench for ps2_host_ctrl: open-drain line model, device frame
// receiver, frame and key-event scoreboards.
module tb_ps2_host_ctrl;
  import ps2_pkg::*;

  localparam int INH   = 20;
  localparam int TMO   = 200;
  localparam int RETRY = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        dev_clk = 1'b1, dev_data = 1'b1;
  logic        ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe, busy;
  logic [10:0] rx_key = '0;
  logic [10:0] key_out;
`ifdef PS2_LED_SYNC_EN
  logic [2:0]  led_state = 3'b000;
`endif

  int n_tests = 0, n_fail = 0, ack_cnt = 0, err_cnt = 0, frames = 0;
  logic [7:0]  exp_q[$];
  logic [10:0] key_q[$];

  ps2_host_ctrl_if cif();

  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(RETRY)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_key      (rx_key),
    .key_out     (key_out),
    .busy        (busy),
`ifdef PS2_LED_SYNC_EN
    .led_state   (led_state),
`endif
    .cmd         (cif)
  );

  always #5 clk = ~clk;

  // Event monitor: ack/err pulse counts and key_out scoreboard.
  always @(negedge clk) begin
    if (cif.cmd_ack === 1'b1) ack_cnt++;
    if (cif.cmd_err === 1'b1) err_cnt++;
    if (cif.cmd_ack === 1'b1 && cif.cmd_err === 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL ack_err_excl: ack=%b err=%b, required not both", cif.cmd_ack, cif.cmd_err);
    end
    if (reset_n && key_out[10] === 1'b1) begin
      n_tests++;
      if (key_q.size() == 0) begin
        n_fail++;
        $display("FAIL key_unexpected: key_out=%h, required no strobe", key_out);
      end else begin
        logic [10:0] ek;
        ek = key_q.pop_front();
        if (key_out !== ek) begin
          n_fail++;
          $display("FAIL key_out: got %h, required %h", key_out, ek);
        end
      end
    end
  end

  task automatic issue_cmd(input logic [7:0] b);
    int t = 0;
    while (cif.cmd_ready !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_ready_wait: ready=%b after %0d cycles, required 1", cif.cmd_ready, t);
    end
    cif.cmd_valid = 1'b1;
    cif.cmd_byte  = b;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [10:0] v);
    rx_key = v;
    @(negedge clk);
    rx_key = '0;
  endtask

  // Device side: wait for request-to-send, clock n_edges falling edges, sample
  // on the low phase, pull data low on edge 11 as the line ack.
  task automatic dev_frame(input int n_edges);
    logic [9:0] bits;
    logic [7:0] eb;
    int t;
    bits = '0;
    t = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 1000) begin
      @(negedge clk); t++;
    end
    if (t >= 1000) begin
      n_tests++; n_fail++;
      $display("FAIL rts_wait: clk_oe=%b data_oe=%b, required request-to-send", ps2_clk_oe, ps2_data_oe);
      return;
    end
    repeat (6) @(negedge clk);
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (6) @(negedge clk);
      if (e <= 10) bits[e-1] = ps2_data;
      dev_clk = 1'b1;
      repeat (6) @(negedge clk);
      if (e == 11) dev_data = 1'b1;
    end
    if (n_edges == 11) begin
      frames++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_unexpected: got %b, required no frame", bits);
      end else begin
        eb = exp_q.pop_front();
        if (bits !== {1'b1, ~^eb, eb}) begin
          n_fail++;
          $display("FAIL frame: got stop/par/data %b, required %b", bits, {1'b1, ~^eb, eb});
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests += 6;
    if (ps2_clk_oe !== 1'b0)  begin n_fail++; $display("FAIL rst_clk_oe: got %b, required 0", ps2_clk_oe); end
    if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_data_oe: got %b, required 0", ps2_data_oe); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (cif.cmd_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b, required 0", cif.cmd_ack); end
    if (cif.cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", cif.cmd_err); end
    if (key_out !== 11'h000)  begin n_fail++; $display("FAIL rst_key_out: got %h, required 000", key_out); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (cif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", cif.cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_cmd_f4();
    int a0 = ack_cnt, e0 = err_cnt;
    issue_cmd(8'hF4);
    exp_q.push_back(8'hF4);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL f4_busy: got %b, required 1", busy); end
    dev_frame(11);
    send_rx(11'h4FA);
    repeat (3) @(negedge clk);
    n_tests += 3;
    if (ack_cnt - a0 != 1) begin n_fail++; $display("FAIL f4_ack: got %0d acks, required 1", ack_cnt - a0); end
    if (err_cnt != e0)     begin n_fail++; $display("FAIL f4_err: got %0d errs, required 0", err_cnt - e0); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL f4_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    int a0 = ack_cnt;
    issue_cmd(8'h0F);
    exp_q.push_back(8'h0F);
    cif.cmd_valid = 1'b1;
    cif.cmd_byte  = 8'hAA;
    repeat (2) @(negedge clk);
    n_tests++;
    if (cif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready: got %b, required 0 while busy", cif.cmd_ready); end
    dev_frame(11);
    cif.cmd_valid = 1'b0;
    send_rx(11'h4FA);
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_not_queued: busy=%b, required 0", busy); end
    issue_cmd(8'h33);
    exp_q.push_back(8'h33);
    dev_frame(11);
    send_rx(11'h4FA);
    repeat (3) @(negedge clk);
    n_tests++;
    if (ack_cnt - a0 != 2) begin n_fail++; $display("FAIL b2b_acks: got %0d, required 2", ack_cnt - a0); end
  endtask

  task automatic test_retry();
    int a0 = ack_cnt, e0 = err_cnt, f0 = frames;
    issue_cmd(8'hF3);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hF3);
      dev_frame(11);
      send_rx(i < 3 ? 11'h4FE : 11'h4FA);
    end
    repeat (3) @(negedge clk);
    n_tests += 3;
    if (frames - f0 != 4)  begin n_fail++; $display("FAIL retry_frames: got %0d, required 4", frames - f0); end
    if (ack_cnt - a0 != 1) begin n_fail++; $display("FAIL retry_ack: got %0d, required 1", ack_cnt - a0); end
    if (err_cnt != e0)     begin n_fail++; $display("FAIL retry_err: got %0d, required 0", err_cnt - e0); end
    a0 = ack_cnt;
    issue_cmd(8'hF2);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hF2);
      dev_frame(11);
      n_tests++;
      if (err_cnt != e0) begin n_fail++; $display("FAIL retry_early_err: err before frame %0d, required none", i + 1); end
      send_rx(11'h4FE);
    end
    repeat (3) @(negedge clk);
    n_tests += 3;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL retry_exhaust_err: got %0d, required 1", err_cnt - e0); end
    if (ack_cnt != a0)     begin n_fail++; $display("FAIL retry_exhaust_ack: got %0d, required 0", ack_cnt - a0); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL retry_exhaust_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_timeout();
    int k = 0;
    issue_cmd(8'h5A);
    dev_frame(4);
    @(negedge clk);
    dev_clk = 1'b0;
    while (k < TMO + 50) begin
      @(negedge clk);
      k++;
      if (k == 6) dev_clk = 1'b1;
      if (cif.cmd_err === 1'b1) break;
    end
    dev_clk = 1'b1;
    // Two synchroniser stages sit between the line edge and its detection.
    n_tests += 3;
    if (k != TMO + 2) begin n_fail++; $display("FAIL timeout_latency: err after %0d cycles, required %0d", k, TMO + 2); end
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_fail++; $display("FAIL timeout_release: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    issue_cmd(8'h12);
    dev_frame(3);
    n_tests++;
    if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL mid_send_bit: data_oe=%b, required 1", ps2_data_oe); end
    #1 reset_n = 1'b0;
    #1;
    n_tests += 2;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_release: clk_oe=%b data_oe=%b, required 0 0", ps2_clk_oe, ps2_data_oe);
    end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (cif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b, required 1", cif.cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_keys();
    int a0;
    key_q.push_back(11'h61C);
    send_rx(11'h61C);
    n_tests++;
    if (key_out !== 11'h61C) begin n_fail++; $display("FAIL key_idle: got %h, required 61C", key_out); end
    key_q.push_back(11'h4FA);
    send_rx(11'h4FA);
    repeat (2) @(negedge clk);
    a0 = ack_cnt;
    issue_cmd(8'hF4);
    exp_q.push_back(8'hF4);
    dev_frame(11);
    key_q.push_back(11'h61C);
    send_rx(11'h61C);
    n_tests++;
    if (key_out !== 11'h61C) begin n_fail++; $display("FAIL key_waitresp: got %h, required 61C", key_out); end
    send_rx(11'h4FA);
    repeat (3) @(negedge clk);
    n_tests++;
    if (ack_cnt - a0 != 1) begin n_fail++; $display("FAIL key_ack: got %0d, required 1", ack_cnt - a0); end
  endtask

`ifdef PS2_LED_SYNC_EN
  task automatic test_led_sync();
    int a0 = ack_cnt;
    led_state = 3'b100;
    exp_q.push_back(8'hED);
    exp_q.push_back(8'h04);
    dev_frame(11);
    send_rx(11'h4FA);
    dev_frame(11);
    send_rx(11'h4FA);
    repeat (5) @(negedge clk);
    n_tests += 2;
    if (ack_cnt - a0 != 1) begin n_fail++; $display("FAIL led_ack: got %0d, required 1", ack_cnt - a0); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL led_idle: busy=%b, required 0", busy); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_byte  = '0;
    test_reset();
    test_cmd_f4();
    test_back_to_back();
    test_retry();
    test_timeout();
    test_reset_mid();
    test_keys();
`ifdef PS2_LED_SYNC_EN
    test_led_sync();
`endif
    repeat (5) @(negedge clk);
    n_tests += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL frames_left: %0d expected frames never seen, required 0", exp_q.size()); end
    if (key_q.size() != 0) begin n_fail++; $display("FAIL keys_left: %0d expected key events never seen, required 0", key_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
